pool_frame_ctrl: RTL and testbench

- Sequences one pooling frame: accepts the conv-result beat stream from the conv engine and generates the in_vld/cnt pair that drives the 2x2 max-pool register bank.
- Holds the completed 3x3 pooled vector until the downstream linear stage takes it, so the next frame cannot overwrite it early.
- Sits between the conv engine (upstream, valid/ready) and the linear layer (downstream, valid/ready).

---
 rtl/pool_frame_ctrl.sv | 121 ++++++++++++
 tb/tb_pool_frame_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_frame_ctrl.sv
// pool_frame_ctrl: sequences one pooling frame between the conv engine and
// the linear stage, driving the 2x2 max-pool bank's in_vld/cnt pair.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                single-cycle frame request, honoured only in IDLE
//   abort                synchronous cancel, highest priority
//   src_vld / src_rdy    conv beat handshake (upstream)
//   pool_vld / pool_cnt  pool bank in_vld and beat index
//   res_vld / res_rdy    pooled vector handshake (downstream)
//   busy                 controller not idle
//   done                 one-cycle pulse on the result handshake
//   frm_cnt              completed-frame counter, wraps

module pool_frame_ctrl #(
    parameter int CNT_MAX = 68,
    parameter int CNT_W   = 7,
    parameter int FRM_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             src_vld,
    output logic             src_rdy,
    output logic             pool_vld,
    output logic [CNT_W-1:0] pool_cnt,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic             busy,
    output logic             done,
    output logic [FRM_W-1:0] frm_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRM_W-1:0]   frm_q, frm_d;

    logic               in_run;
    logic               in_hold;
    logic               accept;
    logic               last_beat;
    logic               res_hs;

    assign in_run    = (state_q == RUN);
    assign in_hold   = (state_q == HOLD);

    // abort masks the beat in the same cycle so it is never counted
    assign accept    = in_run & src_vld & ~abort;
    assign last_beat = (cnt_q == CNT_W'(CNT_MAX));

    // done is the handshake itself, so it fires while state is still HOLD;
    // a start in that cycle therefore falls into HOLD and is dropped
    assign res_hs    = in_hold & res_rdy & ~abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frm_q   <= frm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frm_d   = frm_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_beat) begin
                            state_d = HOLD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (res_rdy) begin
                        state_d = IDLE;
                        frm_d   = frm_q + FRM_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign src_rdy  = in_run & ~abort;
    assign pool_vld = accept;
    assign pool_cnt = cnt_q;
    assign res_vld  = in_hold;
    assign busy     = (state_q != IDLE);
    assign done     = res_hs;
    assign frm_cnt  = frm_q;

endmodule

// File: tb/tb_pool_frame_ctrl.sv
// tb_pool_frame_ctrl: randomized scenario bench for pool_frame_ctrl.
// Expected beat sequences and frame counts come from a frame-level model.

module tb_pool_frame_ctrl;

    localparam int CNT_MAX = 68;
    localparam int CNT_W   = 7;
    localparam int FRM_W   = 16;
    localparam int NBEAT   = CNT_MAX + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             src_vld;
    logic             src_rdy;
    logic             pool_vld;
    logic [CNT_W-1:0] pool_cnt;
    logic             res_vld;
    logic             res_rdy;
    logic             busy;
    logic             done;
    logic [FRM_W-1:0] frm_cnt;

    int n_chk;
    int n_fail;
    int exp_frm;
    int q[$];

    always #5 clk = ~clk;

    pool_frame_ctrl #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W),
        .FRM_W   (FRM_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .src_vld  (src_vld),
        .src_rdy  (src_rdy),
        .pool_vld (pool_vld),
        .pool_cnt (pool_cnt),
        .res_vld  (res_vld),
        .res_rdy  (res_rdy),
        .busy     (busy),
        .done     (done),
        .frm_cnt  (frm_cnt)
    );

    // one start pulse issued from IDLE; returns one cycle later, #1 after edge
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // streams beats with pct% valid probability until res_vld is seen;
    // returns at the negedge of the first HOLD cycle with beats in q
    task automatic stream_frame(input int pct, output int cycles,
                                output int bad);
        bit got;
        got    = 1'b0;
        cycles = 0;
        bad    = 0;
        q.delete();
        for (int i = 0; i < 3000 && !got; i++) begin
            src_vld = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            cycles++;
            if (res_vld === 1'b1) begin
                got = 1'b1;
            end else begin
                if (src_rdy !== 1'b1) bad++;
                if (pool_vld !== src_vld) bad++;
                if (done !== 1'b0) bad++;
                if (pool_vld === 1'b1) q.push_back(int'(pool_cnt));
                @(posedge clk);
                #1;
            end
        end
        if (!got) cycles = -1;
    endtask

    // counts deviations of q from the ideal 0..CNT_MAX beat sequence
    function automatic int seq_errs();
        int e;
        e = (q.size() == NBEAT) ? 0 : 1;
        foreach (q[i]) if (q[i] != i) e++;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_chk++;
        if ({busy, res_vld, done, src_rdy, pool_vld} !== 5'b0 ||
            pool_cnt !== '0 || frm_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b rv=%b done=%b rdy=%b pv=%b cnt=%0d frm=%0d required all 0",
                     busy, res_vld, done, src_rdy, pool_vld, pool_cnt, frm_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_frm = 0;
    endtask

    task automatic test_basic();
        int cyc, bad, e;
        res_rdy = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || src_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: busy=%b src_rdy=%b required 0 0", busy, src_rdy);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        stream_frame(100, cyc, bad);
        e = seq_errs();
        n_chk++;
        if (e != 0 || bad != 0) begin
            n_fail++;
            $display("FAIL basic_seq: beats=%0d seq_errs=%0d bad=%0d required %0d 0 0",
                     q.size(), e, bad, NBEAT);
        end
        n_chk++;
        if (cyc != NBEAT + 1) begin
            n_fail++;
            $display("FAIL basic_latency: res_vld at cycle %0d required %0d", cyc, NBEAT + 1);
        end
        n_chk++;
        if (done !== 1'b1 || src_rdy !== 1'b0 || pool_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hold: done=%b rdy=%b pv=%b required 1 0 0", done, src_rdy, pool_vld);
        end
        src_vld = 1'b0;
        exp_frm++;
        @(posedge clk);
        #1;
        n_chk++;
        if (int'(frm_cnt) != exp_frm || busy !== 1'b0 || done !== 1'b0 || res_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: frm=%0d busy=%b done=%b rv=%b required %0d 0 0 0",
                     frm_cnt, busy, done, res_vld, exp_frm);
        end
    endtask

    task automatic test_gap_stall();
        int cyc, bad, e;
        res_rdy = 1'b0;
        do_start();
        stream_frame(50, cyc, bad);
        e = seq_errs();
        n_chk++;
        if (e != 0 || bad != 0 || cyc < 0) begin
            n_fail++;
            $display("FAIL gap_seq: beats=%0d seq_errs=%0d bad=%0d cyc=%0d required %0d 0 0",
                     q.size(), e, bad, cyc, NBEAT);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            start   = $urandom_range(0, 1);
            src_vld = $urandom_range(0, 1);
            @(negedge clk);
            if (res_vld !== 1'b1 || src_rdy !== 1'b0 || pool_vld !== 1'b0 ||
                busy !== 1'b1 || done !== 1'b0 || pool_cnt !== '0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d bad cycles required 0", bad);
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        src_vld = 1'b0;
        res_rdy = 1'b1;
        @(negedge clk);
        n_chk++;
        if (done !== 1'b1 || res_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: done=%b rv=%b required 1 1", done, res_vld);
        end
        exp_frm++;
        @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || int'(frm_cnt) != exp_frm || res_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: busy=%b frm=%0d rv=%b required 0 %0d 0",
                     busy, frm_cnt, res_vld, exp_frm);
        end
    endtask

    task automatic test_abort();
        int cyc, bad, e, dn;
        res_rdy = 1'b1;
        do_start();
        src_vld = 1'b1;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(negedge clk);
        n_chk++;
        if (int'(pool_cnt) != 30 || pool_vld !== 1'b0 || src_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_beat: cnt=%0d pv=%b rdy=%b required 30 0 0",
                     pool_cnt, pool_vld, src_rdy);
        end
        @(posedge clk);
        #1;
        abort   = 1'b0;
        src_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        n_chk++;
        if (busy !== 1'b0 || pool_cnt !== '0 || res_vld !== 1'b0 ||
            dn != 0 || int'(frm_cnt) != exp_frm) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b cnt=%0d rv=%b dones=%0d frm=%0d required 0 0 0 0 %0d",
                     busy, pool_cnt, res_vld, dn, frm_cnt, exp_frm);
        end
        @(posedge clk);
        #1;
        do_start();
        stream_frame(80, cyc, bad);
        e = seq_errs();
        n_chk++;
        if (e != 0 || bad != 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_refrm: seq_errs=%0d bad=%0d done=%b required 0 0 1", e, bad, done);
        end
        src_vld = 1'b0;
        exp_frm++;
        @(posedge clk);
        #1;
        n_chk++;
        if (int'(frm_cnt) != exp_frm) begin
            n_fail++;
            $display("FAIL abort_frm: frm=%0d required %0d", frm_cnt, exp_frm);
        end
    endtask

    task automatic test_async_reset();
        int cyc, bad;
        res_rdy = 1'b0;
        do_start();
        stream_frame(100, cyc, bad);
        src_vld = 1'b0;
        n_chk++;
        if (res_vld !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: rv=%b busy=%b required 1 1", res_vld, busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (res_vld !== 1'b0 || busy !== 1'b0 || pool_cnt !== '0 ||
            frm_cnt !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_now: rv=%b busy=%b cnt=%0d frm=%0d done=%b required 0 0 0 0 0",
                     res_vld, busy, pool_cnt, frm_cnt, done);
        end
        exp_frm = 0;
        res_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int cyc, bad, e, tot, ign;
        tot = 0;
        ign = 0;
        res_rdy = 1'b1;
        do_start();
        for (int f = 0; f < 3; f++) begin
            stream_frame(100, cyc, bad);
            e = seq_errs();
            tot += e + bad + ((done === 1'b1) ? 0 : 1);
            src_vld = 1'b0;
            exp_frm++;
            // start alongside done must be dropped
            start = 1'b1;
            @(posedge clk);
            #1;
            @(negedge clk);
            if (busy !== 1'b0) ign++;
            if (f < 2) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end else begin
                start = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        n_chk++;
        if (tot != 0) begin
            n_fail++;
            $display("FAIL b2b_seq: %0d sequence errors required 0", tot);
        end
        n_chk++;
        if (ign != 0) begin
            n_fail++;
            $display("FAIL b2b_start_in_done: %0d honoured required 0", ign);
        end
        n_chk++;
        if (int'(frm_cnt) != exp_frm || exp_frm != 3) begin
            n_fail++;
            $display("FAIL b2b_frm: frm=%0d required 3", frm_cnt);
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        exp_frm = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        src_vld = 1'b0;
        res_rdy = 1'b0;
        test_reset();
        test_basic();
        test_gap_stall();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
